// File: rtl/multicore_system_ram_arbiter.sv
// -----------------------------------------------------------------------------
// multicore_system_ram_arbiter
//
// Two-master Avalon-MM arbiter in front of a single-port on-chip RAM
// (1024 x 32, byte-enabled, one-cycle read latency). Master m0 is a core's
// data master; master m1 is a shared DMA/host master. Commands are granted
// combinationally with round-robin priority, so an accepted command reaches
// the RAM in the same cycle. Read data comes back one cycle later and is
// steered to the issuing master through readdatavalid. A saturating counter
// records how many cycles a requesting master was stalled.
//
// Ports:
//   clk, reset             single clock; asynchronous active-high reset
//   m0_* / m1_*            Avalon-MM slave ports (address, byteenable, read,
//                          write, writedata in; waitrequest, readdata,
//                          readdatavalid out)
//   ram_*                  RAM command outputs and ram_readdata input
//   cnt_clear              synchronous clear of the contention counter
//   contention_count       saturating count of stalled-request cycles
// -----------------------------------------------------------------------------
module multicore_system_ram_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int BE_W   = DATA_W / 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,

  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata,

  input  logic              cnt_clear,
  output logic [CNT_W-1:0]  contention_count
);

  typedef enum logic {
    MASTER_0 = 1'b0,
    MASTER_1 = 1'b1
  } master_e;

  // Request / grant
  logic w_req0;
  logic w_req1;
  logic w_gnt0;
  logic w_gnt1;
  logic w_rd_acc0;
  logic w_rd_acc1;

  // Round-robin pointer and read-return tracking
  master_e r_last_grant;
  logic    r_rd_pend;
  master_e r_rd_owner;

  logic [CNT_W-1:0] r_contention_count;

  assign w_req0 = m0_read | m0_write;
  assign w_req1 = m1_read | m1_write;

  // Grant is purely combinational so acceptance adds no latency. Under
  // contention the master that did not win last time goes first. Reset
  // suppresses every grant, which also forces both waitrequests high.
  // NOTE: every signal assigned in an always_comb gets a default on entry;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!reset) begin
      if (w_req0 && w_req1) begin
        w_gnt0 = (r_last_grant == MASTER_1);
        w_gnt1 = (r_last_grant == MASTER_0);
      end else begin
        w_gnt0 = w_req0;
        w_gnt1 = w_req1;
      end
    end
  end

  assign w_rd_acc0 = w_gnt0 & m0_read;
  assign w_rd_acc1 = w_gnt1 & m1_read;

  assign m0_waitrequest = ~w_gnt0;
  assign m1_waitrequest = ~w_gnt1;

  // Command mux toward the RAM. The data fields follow m0 unless m1 holds
  // the grant; they are don't-care whenever chipselect is low.
  always_comb begin
    ram_address    = m0_address;
    ram_byteenable = m0_byteenable;
    ram_writedata  = m0_writedata;
    if (w_gnt1) begin
      ram_address    = m1_address;
      ram_byteenable = m1_byteenable;
      ram_writedata  = m1_writedata;
    end
  end

  assign ram_chipselect = w_gnt0 | w_gnt1;
  assign ram_write      = (w_gnt0 & m0_write) | (w_gnt1 & m1_write);
  assign ram_clken      = ~reset;

  // The pointer moves only when somebody was granted, so a stalled master
  // that drops its request does not lose its turn. The read tracker reloads
  // every cycle, which lets back-to-back reads pipeline at one per cycle;
  // an async reset discards any read still in flight.
  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= MASTER_1;
      r_rd_pend    <= 1'b0;
      r_rd_owner   <= MASTER_0;
    end else begin
      if (w_gnt0 || w_gnt1) begin
        r_last_grant <= w_gnt1 ? MASTER_1 : MASTER_0;
      end
      r_rd_pend  <= w_rd_acc0 | w_rd_acc1;
      r_rd_owner <= w_rd_acc1 ? MASTER_1 : MASTER_0;
    end
  end

  // Read data is shared wiring; only readdatavalid is steered.
  assign m0_readdata      = ram_readdata;
  assign m1_readdata      = ram_readdata;
  assign m0_readdatavalid = r_rd_pend & (r_rd_owner == MASTER_0);
  assign m1_readdatavalid = r_rd_pend & (r_rd_owner == MASTER_1);

  // Contention counter: with both masters requesting exactly one of them is
  // stalled. Clear wins over increment; the count sticks at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_contention_count <= '0;
    end else if (cnt_clear) begin
      r_contention_count <= '0;
    end else if (w_req0 && w_req1 && !(&r_contention_count)) begin
      r_contention_count <= r_contention_count + CNT_W'(1);
    end
  end

  assign contention_count = r_contention_count;

endmodule

// File: tb/tb_multicore_system_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_multicore_system_ram_arbiter
//
// Directed bench for the two-master RAM arbiter. A behavioural RAM answers
// the DUT's RAM port. A transaction-level model (shadow memory, whose-turn
// flag, expected read in flight, integer counter) predicts every output and
// is compared against the DUT on each falling edge. Hand-computed literal
// expectations pin the model to the intended behaviour.
// -----------------------------------------------------------------------------
module tb_multicore_system_ram_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int CNT_W  = 16;
  localparam int DEPTH  = 1024;

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] m0_address,   m1_address;
  logic [BE_W-1:0]   m0_byteenable, m1_byteenable;
  logic              m0_read,      m1_read;
  logic              m0_write,     m1_write;
  logic [DATA_W-1:0] m0_writedata, m1_writedata;
  logic              m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0] m0_readdata,  m1_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic [ADDR_W-1:0] ram_address;
  logic [BE_W-1:0]   ram_byteenable;
  logic              ram_chipselect;
  logic              ram_write;
  logic [DATA_W-1:0] ram_writedata;
  logic              ram_clken;
  logic [DATA_W-1:0] ram_readdata;
  logic              cnt_clear;
  logic [CNT_W-1:0]  contention_count;

  int n_checks = 0;
  int n_errors = 0;

  multicore_system_ram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .CNT_W(CNT_W)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .ram_address      (ram_address),
    .ram_byteenable   (ram_byteenable),
    .ram_chipselect   (ram_chipselect),
    .ram_write        (ram_write),
    .ram_writedata    (ram_writedata),
    .ram_clken        (ram_clken),
    .ram_readdata     (ram_readdata),
    .cnt_clear        (cnt_clear),
    .contention_count (contention_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural RAM: byte-enabled writes, one-cycle registered reads.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] ram_mem [0:DEPTH-1];

  initial begin
    for (int i = 0; i < DEPTH; i++) ram_mem[i] = '0;
    ram_readdata = '0;
  end

  always @(posedge clk) begin
    if (ram_clken && ram_chipselect) begin
      if (ram_write) begin
        for (int b = 0; b < BE_W; b++)
          if (ram_byteenable[b]) ram_mem[ram_address][b*8 +: 8] <= ram_writedata[b*8 +: 8];
      end else begin
        ram_readdata <= ram_mem[ram_address];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Transaction-level model and per-cycle comparison.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] shadow [0:DEPTH-1];
  int                md_last_winner;   // 0 or 1: who won the most recent grant
  bit                md_pend;
  int                md_pend_owner;
  logic [DATA_W-1:0] md_pend_data;
  int                md_count;

  initial begin
    for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
    md_last_winner = 1;
    md_pend        = 0;
    md_pend_owner  = 0;
    md_pend_data   = '0;
    md_count       = 0;
  end

  always @(negedge clk) begin
    int                win;
    bit                rq0, rq1;
    logic [ADDR_W-1:0] a;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wd;
    bit                is_wr;

    rq0 = m0_read | m0_write;
    rq1 = m1_read | m1_write;
    win = -1;
    if (!reset) begin
      if (rq0 && rq1)  win = 1 - md_last_winner;
      else if (rq0)    win = 0;
      else if (rq1)    win = 1;
    end

    check("m0_waitrequest", m0_waitrequest, (win == 0) ? 0 : 1);
    check("m1_waitrequest", m1_waitrequest, (win == 1) ? 0 : 1);
    check("ram_chipselect", ram_chipselect, (win >= 0) ? 1 : 0);
    check("ram_clken", ram_clken, reset ? 0 : 1);
    check("m0_readdatavalid", m0_readdatavalid, (!reset && md_pend && md_pend_owner == 0) ? 1 : 0);
    check("m1_readdatavalid", m1_readdatavalid, (!reset && md_pend && md_pend_owner == 1) ? 1 : 0);
    if (!reset && md_pend) begin
      if (md_pend_owner == 0) check("m0_readdata", m0_readdata, md_pend_data);
      else                    check("m1_readdata", m1_readdata, md_pend_data);
    end
    check("contention_count", 32'(contention_count), reset ? 0 : md_count);

    a = '0; be = '0; wd = '0; is_wr = 0;
    if (win == 0) begin a = m0_address; be = m0_byteenable; wd = m0_writedata; is_wr = m0_write; end
    if (win == 1) begin a = m1_address; be = m1_byteenable; wd = m1_writedata; is_wr = m1_write; end
    if (win >= 0) begin
      check("ram_address", 32'(ram_address), 32'(a));
      check("ram_write", ram_write, is_wr);
      check("ram_byteenable", 32'(ram_byteenable), 32'(be));
      check("ram_writedata", ram_writedata, wd);
    end

    // Advance the model to the state after the coming rising edge.
    if (reset) begin
      md_last_winner = 1;
      md_pend        = 0;
      md_pend_owner  = 0;
      md_count       = 0;
    end else begin
      md_pend = 0;
      if (win >= 0) begin
        md_last_winner = win;
        if (is_wr) begin
          for (int b = 0; b < BE_W; b++)
            if (be[b]) shadow[a][b*8 +: 8] = wd[b*8 +: 8];
        end else begin
          md_pend       = 1;
          md_pend_owner = win;
          md_pend_data  = shadow[a];
        end
      end
      if (cnt_clear)            md_count = 0;
      else if (rq0 && rq1)      md_count = (md_count >= 65535) ? 65535 : md_count + 1;
    end
  end

  // ---------------------------------------------------------------------------
  // Observation logs used by the literal expectations.
  // ---------------------------------------------------------------------------
  int                glog [$];
  logic [DATA_W-1:0] rx0  [$];
  logic [DATA_W-1:0] rx1  [$];

  always @(negedge clk) begin
    if (!reset) begin
      if ((m0_read || m0_write) && !m0_waitrequest) glog.push_back(0);
      if ((m1_read || m1_write) && !m1_waitrequest) glog.push_back(1);
    end
    if (m0_readdatavalid) rx0.push_back(m0_readdata);
    if (m1_readdatavalid) rx1.push_back(m1_readdata);
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
  endtask

  task automatic m0_cmd(input bit wr, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
    m0_read = ~wr; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be;
  endtask

  task automatic m1_cmd(input bit wr, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
    m1_read = ~wr; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be;
  endtask

  task automatic check_glog(input string name, input int exp_seq [$]);
    check($sformatf("%s_len", name), glog.size(), exp_seq.size());
    for (int i = 0; i < exp_seq.size() && i < glog.size(); i++)
      check($sformatf("%s_%0d", name, i), glog[i], exp_seq[i]);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b1; cnt_clear = 1'b0;
    idle();
    m0_address = '0; m1_address = '0; m0_writedata = '0; m1_writedata = '0;
    m0_byteenable = '0; m1_byteenable = '0;
    repeat (3) step();
    check("rst_m0_wait", m0_waitrequest, 1);
    check("rst_m1_wait", m1_waitrequest, 1);
    check("rst_chipselect", ram_chipselect, 0);
    check("rst_clken", ram_clken, 0);
    check("rst_count", 32'(contention_count), 0);
    reset = 1'b0;
    step();

    // First contention after reset: m0 first, then m1.
    glog.delete();
    m0_cmd(0, 10'd0, '0, 4'hF); m1_cmd(0, 10'd0, '0, 4'hF);
    step(); step();
    idle(); step();
    check_glog("first_contention", '{0, 1});

    // Single master write then read of the same address.
    rx0.delete(); rx1.delete();
    m0_cmd(1, 10'd5, 32'hDEADBEEF, 4'hF); #1;
    check("single_wr_wait", m0_waitrequest, 0);
    step();
    m0_cmd(0, 10'd5, '0, 4'hF); #1;
    check("single_rd_wait", m0_waitrequest, 0);
    step();
    idle(); step();
    check("single_rx0_len", rx0.size(), 1);
    if (rx0.size() > 0) check("single_rx0_data", rx0[0], 32'hDEADBEEF);
    check("single_rx1_len", rx1.size(), 0);

    // Contention: six cycles of overlapping reads.
    m0_cmd(1, 10'd1, 32'h11111111, 4'hF); step();
    idle(); m1_cmd(1, 10'd2, 32'h22222222, 4'hF); step();
    idle(); cnt_clear = 1'b1; step();
    cnt_clear = 1'b0;
    glog.delete(); rx0.delete(); rx1.delete();
    m0_cmd(0, 10'd1, '0, 4'hF); m1_cmd(0, 10'd2, '0, 4'hF);
    repeat (6) step();
    idle(); step();
    check_glog("contention", '{0, 1, 0, 1, 0, 1});
    check("contention_rx0_len", rx0.size(), 3);
    check("contention_rx1_len", rx1.size(), 3);
    foreach (rx0[i]) check($sformatf("contention_rx0_%0d", i), rx0[i], 32'h11111111);
    foreach (rx1[i]) check($sformatf("contention_rx1_%0d", i), rx1[i], 32'h22222222);
    check("contention_count_6", 32'(contention_count), 6);

    // Byte enables: m1 clears lanes 0 and 2 of an all-ones word.
    rx0.delete();
    m0_cmd(1, 10'd9, 32'hFFFFFFFF, 4'hF); step();
    idle(); m1_cmd(1, 10'd9, 32'h00000000, 4'h5); step();
    idle(); m0_cmd(0, 10'd9, '0, 4'hF); step();
    idle(); step();
    check("be_rx0_len", rx0.size(), 1);
    if (rx0.size() > 0) check("be_rx0_data", rx0[0], 32'hFF00FF00);

    // Simultaneous m0 write / m1 read to the same address: m1 won last? no,
    // m0 did, so m1's read goes first and sees the old (zero) contents.
    rx1.delete(); glog.delete();
    m0_cmd(1, 10'd20, 32'hAAAA5555, 4'hF); m1_cmd(0, 10'd20, '0, 4'hF);
    step();
    m1_read = 1'b0;
    step();
    idle(); step();
    check_glog("rw_serial", '{1, 0});
    check("rw_rx1_len", rx1.size(), 1);
    if (rx1.size() > 0) check("rw_rx1_data", rx1[0], 32'h00000000);

    // Stalled master drops its request; the pointer must not move on the
    // idle cycle in between.
    glog.delete();
    m0_cmd(0, 10'd20, '0, 4'hF); m1_cmd(0, 10'd20, '0, 4'hF); step();
    idle(); step();
    m0_cmd(0, 10'd20, '0, 4'hF); m1_cmd(0, 10'd20, '0, 4'hF); step();
    idle(); step();
    check_glog("drop_stall", '{1, 0});

    // Reset while m1's read is in flight.
    rx1.delete();
    m1_cmd(0, 10'd9, '0, 4'hF); step();
    reset = 1'b1;
    m0_cmd(0, 10'd1, '0, 4'hF); m1_cmd(0, 10'd2, '0, 4'hF); #1;
    check("midrst_m0_wait", m0_waitrequest, 1);
    check("midrst_m1_wait", m1_waitrequest, 1);
    step(); step();
    check("midrst_rx1_len", rx1.size(), 0);
    reset = 1'b0; #1;
    check("post_rst_m0_wait", m0_waitrequest, 0);
    check("post_rst_m1_wait", m1_waitrequest, 1);
    step();
    idle(); step(); step();

    // Counter saturation and clear under continuous contention.
    m0_cmd(0, 10'd0, '0, 4'hF); m1_cmd(0, 10'd0, '0, 4'hF);
    repeat (70000) step();
    check("cnt_saturated", 32'(contention_count), 32'h0000FFFF);
    cnt_clear = 1'b1; step();
    cnt_clear = 1'b0;
    check("cnt_cleared", 32'(contention_count), 0);
    step();
    check("cnt_after_clear", 32'(contention_count), 1);
    idle(); step(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
